input_debouncer: RTL and testbench
==================================

# input_debouncer

Upstream conditioning stage for the `fsm` block. It takes the asynchronous, possibly bouncy external input `raw_in`, synchronizes it into the `clk` domain and debounces it. It drives the clean level `a_out`, which feeds `fsm.a`, plus single-cycle `rise`/`fall` edge strobes for the FSM stage and its monitors.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flop count; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to accept a new level; legal range ≥ 2.
- `CNT_W`, 8: width of `glitch_cnt`; only used with `DEBOUNCE_GLITCH_CNT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `raw_in`  in  1  asynchronous raw input.
- `a_out`  out  1  debounced level; drives `fsm.a`.
- `rise`  out  1  one-cycle strobe; high during the first cycle `a_out`=1.
- `fall`  out  1  one-cycle strobe; high during the first cycle `a_out`=0.
- `glitch_cnt`  out  CNT_W  aborted-transition count; present only with `DEBOUNCE_GLITCH_CNT_EN`.

## Operation
- Synchronizer:
  - Shift chain of `SYNC_STAGES` flops, reset to 0.
  - `s` is the last stage output.
  - No logic between stages.
- FSM states and transitions:
  - `LOW` (a_out=0):
    - s=1 → `CHK_HI`, cnt←1.
    - Otherwise stay.
  - `CHK_HI` (a_out=0):
    - s=0 → `LOW`; this is a glitch.
    - s=1 and cnt==DEBOUNCE_CYCLES-1 → `HIGH`.
    - s=1 otherwise → cnt←cnt+1.
  - `HIGH` (a_out=1):
    - s=0 → `CHK_LO`, cnt←1.
    - Otherwise stay.
  - `CHK_LO` (a_out=1):
    - s=1 → `HIGH`; this is a glitch.
    - s=0 and cnt==DEBOUNCE_CYCLES-1 → `LOW`.
    - s=0 otherwise → cnt←cnt+1.
- Outputs and counter:
  - `a_out`, `rise`, `fall` are registered. None is decoded combinationally from the state.
  - `rise` is set on the `CHK_HI`→`HIGH` edge only. `fall` is set on the `CHK_LO`→`LOW` edge only.
  - `rise` and `fall` are never high together, and neither is high for two consecutive cycles.
  - cnt width is clog2(DEBOUNCE_CYCLES)+1 bits. It is reloaded to 1 on every entry to a CHK state and never wraps.
- Reset values:
  - state=`LOW`, cnt=0, sync chain=0.
  - `a_out`=0, `rise`=0, `fall`=0, `glitch_cnt`=0.
  - All apply immediately on `rst` assertion, independent of `clk`.
- Reset mid-operation:
  - Any state is abandoned, and no `fall` is generated for the forced low.
  - After release with `raw_in`=1, the normal `LOW`→`CHK_HI`→`HIGH` path runs and produces one `rise`.

## Timing
- Latency:
  - `raw_in` is stable from before clk edge E0.
  - `a_out` and the strobe change at edge E(SYNC_STAGES+DEBOUNCE_CYCLES-1). With defaults this is the 6th rising edge, counting E0 as the 1st.
- Acceptance window: a level is accepted only if s holds it for DEBOUNCE_CYCLES consecutive samples, counting the sample that left the stable state.
- Shorter pulses produce no change on `a_out` and no strobe. With defaults, any `raw_in` pulse shorter than 4 cycles is rejected.
- Strobe width: exactly one clk period.
- Throughput: minimum spacing between a `rise` and the following `fall` is DEBOUNCE_CYCLES cycles.

## Configuration
- Macro: `DEBOUNCE_GLITCH_CNT_EN`.
- Defined:
  - `glitch_cnt` port exists.
  - It increments by 1 on every `CHK_HI`→`LOW` or `CHK_LO`→`HIGH` transition.
  - It saturates at 2^CNT_W-1 and is cleared only by `rst`.
- Undefined:
  - Port and counter logic are absent.
  - FSM, outputs and timing are identical to the defined case.

## Test plan
All scenarios use defaults and a 20-time-unit clk period.
- **Reset and idle:** `rst`=1 with `raw_in`=1, then release. Required: `a_out`=0 during reset; exactly one `rise` 6 edges after release; `a_out`=1 from that edge on.
- **Clean rise:** `raw_in` 0→1 before edge E0. Required: `a_out`=1 and `rise`=1 at E5; `rise`=0 at E6; `fall` stays 0 throughout.
- **Clean fall:** from `HIGH`, `raw_in` 1→0. Required: `a_out`=0 and `fall`=1 for exactly one cycle at E5.
- **Glitch rejection:** from `LOW`, pulse `raw_in` high for 3 cycles. Required: `a_out`, `rise`, `fall` stay 0; `glitch_cnt` goes 0→1 when the macro is defined.
- **Glitch-counter saturation:** with `CNT_W`=2 and the macro defined, apply 5 rejected pulses. Required: `glitch_cnt` reads 1,2,3,3,3.
- **Async reset mid-check:** assert `rst` between clk edges while in `CHK_LO` with `a_out`=1. Required: `a_out`=0 immediately, before the next edge, and no `fall` pulse.

Source files
------------

// File: rtl/input_debouncer.sv
// Two-flop-style synchronizer followed by a four-state debounce FSM with registered level and edge strobes.
// Optional aborted-transition counter on glitch_cnt, enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw_in,
  output logic             a_out,
  output logic             rise,
  output logic             fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_cnt
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2)     begin : g_bad_sync  $error("SYNC_STAGES must be >= 2");     end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb   $error("DEBOUNCE_CYCLES must be >= 2"); end
  if (CNT_W < 1)           begin : g_bad_cnt_w $error("CNT_W must be >= 1");           end

  typedef enum logic [1:0] {LOW, CHK_HI, HIGH, CHK_LO} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   a_d, rise_d, fall_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      a_out   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_out   <= a_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_out;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      LOW: begin
        if (s) begin
          state_d = CHK_HI;
          cnt_d   = CW'(1);
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          a_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = CHK_LO;
          cnt_d   = CW'(1);
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          a_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = LOW;
    endcase
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // A glitch is a check state falling back to the level it started from.
  logic glitch;
  assign glitch = ((state_q == CHK_HI) && !s) || ((state_q == CHK_LO) && s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             glitch_cnt <= '0;
    else if (glitch && (glitch_cnt != '1)) glitch_cnt <= glitch_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: per-cycle vector table plus hand sequences for async reset and glitch saturation.
`timescale 1ns/1ps
module tb_input_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic raw_in;
  logic a_out, rise, fall;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
  logic [1:0] sat_cnt;
  logic       sat_a, sat_rise, sat_fall;

  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .a_out(a_out), .rise(rise), .fall(fall), .glitch_cnt(glitch_cnt)
  );

  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .a_out(sat_a), .rise(sat_rise), .fall(sat_fall), .glitch_cnt(sat_cnt)
  );
`else
  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .a_out(a_out), .rise(rise), .fall(fall)
  );
`endif

  typedef struct {
    logic raw;
    logic a;
    logic r;
    logic f;
    int   g;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic raw, input logic a, input logic r, input logic f,
                     input int g, input int n);
    vec_t v;
    v.raw = raw; v.a = a; v.r = r; v.f = f; v.g = g;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Drive at posedge+5, sample at the following posedge+5.
  task automatic step(input logic raw);
    raw_in = raw;
    @(posedge clk);
    #5;
  endtask

  initial begin
    // idle
    add(0, 0, 0, 0, 0, 2);
    // clean rise: a_out/rise at the 6th edge
    add(1, 0, 0, 0, 0, 5); add(1, 1, 1, 0, 0, 1); add(1, 1, 0, 0, 0, 2);
    // clean fall
    add(0, 1, 0, 0, 0, 5); add(0, 0, 0, 1, 0, 1); add(0, 0, 0, 0, 0, 2);
    // 3-cycle high pulse is rejected
    add(1, 0, 0, 0, 0, 3); add(0, 0, 0, 0, 0, 2); add(0, 0, 0, 0, 1, 3);
    // 4-cycle high pulse is accepted; fall follows rise after exactly 4 cycles
    add(1, 0, 0, 0, 1, 4); add(0, 0, 0, 0, 1, 1); add(0, 1, 1, 0, 1, 1);
    add(0, 1, 0, 0, 1, 3); add(0, 0, 0, 1, 1, 1); add(0, 0, 0, 0, 1, 1);
    // back to HIGH
    add(1, 0, 0, 0, 1, 5); add(1, 1, 1, 0, 1, 1); add(1, 1, 0, 0, 1, 1);
    // 3-cycle low pulse is rejected
    add(0, 1, 0, 0, 1, 3); add(1, 1, 0, 0, 1, 2); add(1, 1, 0, 0, 2, 3);

    rst    = 1'b1;
    raw_in = 1'b0;
    repeat (2) @(posedge clk);
    #5;
    check("reset_a_out", a_out, 0);
    check("reset_rise",  rise,  0);
    check("reset_fall",  fall,  0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("reset_glitch_cnt", glitch_cnt, 0);
`endif
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].raw);
      check($sformatf("vec%0d_a_out", i), a_out, vecs[i].a);
      check($sformatf("vec%0d_rise",  i), rise,  vecs[i].r);
      check($sformatf("vec%0d_fall",  i), fall,  vecs[i].f);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check($sformatf("vec%0d_glitch_cnt", i), glitch_cnt, vecs[i].g);
`endif
    end

    // Async reset while in CHK_LO: a_out drops before the next edge, no fall.
    step(1'b0);
    step(1'b0);
    step(1'b0);
    check("chk_lo_a_out", a_out, 1);
    rst    = 1'b1;
    raw_in = 1'b1;
    #1;
    check("async_rst_a_out", a_out, 0);
    check("async_rst_fall",  fall,  0);
    repeat (2) @(posedge clk);
    #5;
    check("in_rst_a_out", a_out, 0);
    check("in_rst_rise",  rise,  0);
    check("in_rst_fall",  fall,  0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1'b1);
      check($sformatf("post_rst%0d_rise",  k), rise,  (k == 5) ? 1 : 0);
      check($sformatf("post_rst%0d_a_out", k), a_out, (k >= 5) ? 1 : 0);
      check($sformatf("post_rst%0d_fall",  k), fall,  0);
    end

    // Five rejected low pulses from HIGH.
    for (int p = 0; p < 5; p++) begin
      repeat (3) step(1'b0);
      repeat (5) step(1'b1);
      check($sformatf("sat%0d_a_out", p), a_out, 1);
      check($sformatf("sat%0d_fall",  p), fall,  0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check($sformatf("sat%0d_glitch_cnt", p), glitch_cnt, p + 1);
      check($sformatf("sat%0d_cnt_w2", p), sat_cnt, (p < 3) ? p + 1 : 3);
      check($sformatf("sat%0d_sat_a", p), sat_a, 1);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
